ddr_word_aligner: RTL
=====================

Name: ddr_word_aligner

Overview:
- Sits directly downstream of the DDR input register. Consumes its 2-bit per-clock output (bit 0 is the rising-edge sample, bit 1 the falling-edge sample) and deserializes it into WIDTH-bit parallel words.
- A training-pattern aligner applies a bit-offset (bitslip) so word boundaries match the transmitter's framing, then reports lock.
- Forms the input-side word path feeding fabric logic.

Parameters:
- WIDTH, 8, output word width; even, 4..16.
- TRAIN_PATTERN, 8'h5C, WIDTH-bit training word, transmitted MSB first.
- LOCK_COUNT, 4, consecutive pattern matches required to declare lock; 1..15.

Ports:
- C  input  1  clock; the DDR register's clock domain.
- R  input  1  synchronous reset, active-high.
- DIN  input  2  DDR register output; DIN[0] is the earlier bit, DIN[1] the later bit.
- DIN_VALID  input  1  DIN carries a new bit pair this cycle; ties to the DDR register's enable.
- ALIGN_EN  input  1  1 = run/keep alignment; 0 = hold current offset.
- Q  output  WIDTH  aligned word; MSB is the earliest bit.
- Q_VALID  output  1  one-cycle pulse, Q updated.
- LOCKED  output  1  alignment achieved.
- SLIP_CNT  output  $clog2(WIDTH)  current bit offset.
- ALIGN_ERR  output  1  one-cycle pulse: a full sweep of all WIDTH offsets found no match.

Behaviour:
- Reset (R=1 at a rising edge of C):
  - Q=0, Q_VALID=0, LOCKED=0, SLIP_CNT=0, ALIGN_ERR=0.
  - Shift register, pair counter, match counter and sweep counter are cleared; state = IDLE.
  - R dominates DIN_VALID and ALIGN_EN in the same cycle.
  - A reset mid-word discards the partial word.
- Shift register:
  - sr is 2*WIDTH bits.
  - On DIN_VALID: sr <= {sr[2W-3:0], DIN[0], DIN[1]}, so the newest bit lands at the LSB.
  - No shift when DIN_VALID=0.
- Word boundary:
  - Pair counter counts 0..WIDTH/2-1 on DIN_VALID, wrapping to 0.
  - Boundary = DIN_VALID while the counter = WIDTH/2-1.
  - At a boundary: Q <= sr_next[SLIP_CNT+WIDTH-1 : SLIP_CNT], and Q_VALID=1 in the following cycle only.
  - Latency: Q valid 1 cycle after the last pair of the word is accepted.
  - Q_VALID pulses for every word regardless of lock state; consumers gate on LOCKED.
- FSM (evaluated on the word produced at each boundary):
  - IDLE:
    - Offset held; LOCKED held.
    - ALIGN_EN=1 -> SEARCH; this clears LOCKED, the match counter and the sweep counter, and keeps SLIP_CNT.
  - SEARCH:
    - Word == TRAIN_PATTERN -> CONFIRM, with match counter = 1. If LOCK_COUNT = 1, go straight to LOCKED instead.
    - Otherwise SLIP_CNT increments, wrapping WIDTH-1 -> 0, and the sweep counter increments.
    - When the sweep counter reaches WIDTH: ALIGN_ERR pulses for 1 cycle, the sweep counter returns to 0, and the search continues.
  - CONFIRM:
    - Match -> match counter increments; reaching LOCK_COUNT -> LOCKED.
    - Mismatch -> SEARCH, SLIP_CNT+1, match counter = 0.
  - LOCKED:
    - LOCKED=1; data is no longer checked.
    - Offset is frozen until ALIGN_EN falls and rises again.
  - ALIGN_EN=0 in any state -> IDLE at the next clock. SLIP_CNT and LOCKED are held.
- Offset timing: a new SLIP_CNT applies from the next boundary. The 2W-bit sr holds enough history that no word is discarded.
- Simultaneous events:
  - A boundary and an ALIGN_EN fall in the same cycle: the word is output but not evaluated.
  - A boundary and an ALIGN_EN rise in the same cycle: the word is not evaluated; evaluation starts at the next boundary.

Decomposition:
- Package ddr_word_aligner_pkg holds:
  - the state enum (IDLE, SEARCH, CONFIRM, LOCKED);
  - the function clog2 width for SLIP_CNT;
  - constants for the parameter range checks.
- One natural sub-module: ddr_word_gearbox. It contains sr, the pair counter, boundary detection and the offset window mux, and outputs the word plus a boundary strobe.
- The aligner FSM stays in the top.

Test Plan:
All cases use WIDTH=8, TRAIN_PATTERN=8'h5C, LOCK_COUNT=4.
1. Aligned stream:
   - Stimulus: repeated 0x5C MSB first, DIN_VALID=1 every cycle, ALIGN_EN=1 from reset release.
   - Response: Q_VALID every 4th cycle; first words Q=8'h5C; LOCKED=1 after the 4th matching word; SLIP_CNT=0.
2. Skewed stream:
   - Stimulus: 3 zero bits prepended, then repeated 0x5C.
   - Response: SLIP_CNT sweeps 0..5; LOCKED within 12 words; final SLIP_CNT=5; Q=8'h5C thereafter.
3. No pattern:
   - Stimulus: constant 8'h00 data with ALIGN_EN=1.
   - Response: ALIGN_ERR pulses once every 8 words; SLIP_CNT wraps 7->0; LOCKED stays 0.
4. Confirm failure:
   - Stimulus: aligned 0x5C x2, then 0xA3, then 0x5C.
   - Response: the CONFIRM mismatch returns to SEARCH with SLIP_CNT=1; LOCKED=0.
5. Gapped valid and reset:
   - Stimulus: DIN_VALID toggles 1/0, with an aligned stream.
   - Response: a word every 8 cycles with identical Q values. R=1 mid-word clears all outputs to 0; the next word completes 4 valid pairs after R falls.
6. Hold and relock:
   - Stimulus: after lock, drop ALIGN_EN and send garbage; then raise ALIGN_EN.
   - Response: with ALIGN_EN low, LOCKED stays 1 and SLIP_CNT is unchanged. When ALIGN_EN rises, LOCKED clears next cycle and the aligner relocks on 0x5C.

Source files
------------

// File: rtl/ddr_word_aligner_pkg.sv
// Shared types and helpers for the DDR word aligner and its gearbox.
// Holds the aligner state encoding, the parameter limits and the width helper.
package ddr_word_aligner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CONFIRM,
        ST_LOCKED
    } align_state_e;

    localparam int WIDTH_MIN      = 4;
    localparam int WIDTH_MAX      = 16;
    localparam int LOCK_COUNT_MIN = 1;
    localparam int LOCK_COUNT_MAX = 15;
    localparam int MATCH_CNT_W    = 4;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2w(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_word_gearbox.sv
// Deserializes DDR bit pairs into a 2*WIDTH history register and selects the
// WIDTH-bit word at the requested bit offset on each word boundary.
module ddr_word_gearbox
    import ddr_word_aligner_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SLIP_W = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [1:0]        din_i,
    input  logic              din_valid_i,
    input  logic [SLIP_W-1:0] slip_i,
    output logic [WIDTH-1:0]  word_o,
    output logic              boundary_o
);

    localparam int              PAIR_W    = clog2w(WIDTH / 2);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(WIDTH / 2 - 1);

    logic [2*WIDTH-1:0] sr_q;
    logic [2*WIDTH-1:0] sr_d;
    logic [PAIR_W-1:0]  pair_q;
    logic [PAIR_W-1:0]  pair_d;
    logic [WIDTH-1:0]   window [WIDTH];

    // din_i[0] is the earlier bit, so it lands one place above the newest bit.
    always_comb begin
        sr_d   = sr_q;
        pair_d = pair_q;
        if (din_valid_i) begin
            sr_d   = {sr_q[2*WIDTH-3:0], din_i[0], din_i[1]};
            pair_d = (pair_q == PAIR_LAST) ? '0 : pair_q + PAIR_W'(1);
        end
    end

    assign boundary_o = din_valid_i && (pair_q == PAIR_LAST);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_window
        assign window[gi] = sr_d[gi +: WIDTH];
    end

    assign word_o = window[slip_i];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr_q   <= '0;
            pair_q <= '0;
        end else begin
            sr_q   <= sr_d;
            pair_q <= pair_d;
        end
    end

endmodule

// File: rtl/ddr_word_aligner.sv
// DDR input word aligner: deserializes bit pairs into words and bitslips until
// the training pattern is seen LOCK_COUNT times in a row, then reports lock.
module ddr_word_aligner
    import ddr_word_aligner_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 'h5C,
    parameter int               LOCK_COUNT    = 4
) (
    input  logic                       C,
    input  logic                       R,
    input  logic [1:0]                 DIN,
    input  logic                       DIN_VALID,
    input  logic                       ALIGN_EN,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VALID,
    output logic                       LOCKED,
    output logic [clog2w(WIDTH)-1:0]   SLIP_CNT,
    output logic                       ALIGN_ERR
);

    localparam int            SW        = clog2w(WIDTH);
    localparam logic [SW-1:0] SLIP_LAST = SW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH % 2) != 0) begin : g_bad_width
        $error("ddr_word_aligner: WIDTH must be even and within 4..16");
    end
    if (LOCK_COUNT < LOCK_COUNT_MIN || LOCK_COUNT > LOCK_COUNT_MAX) begin : g_bad_lock
        $error("ddr_word_aligner: LOCK_COUNT must be within 1..15");
    end

    align_state_e           state_q;
    logic [WIDTH-1:0]       q_q;
    logic                   q_valid_q;
    logic                   locked_q;
    logic [SW-1:0]          slip_q;
    logic [SW-1:0]          sweep_q;
    logic [MATCH_CNT_W-1:0] match_q;
    logic                   align_err_q;

    logic [WIDTH-1:0]       word;
    logic                   boundary;
    logic                   pattern_hit;
    logic [SW-1:0]          slip_inc;
    logic [MATCH_CNT_W-1:0] match_inc;

    ddr_word_gearbox #(
        .WIDTH  (WIDTH),
        .SLIP_W (SW)
    ) u_gearbox (
        .clk_i       (C),
        .srst_i      (R),
        .din_i       (DIN),
        .din_valid_i (DIN_VALID),
        .slip_i      (slip_q),
        .word_o      (word),
        .boundary_o  (boundary)
    );

    assign pattern_hit = (word == TRAIN_PATTERN);
    assign slip_inc    = (slip_q == SLIP_LAST) ? '0 : slip_q + SW'(1);
    assign match_inc   = match_q + MATCH_CNT_W'(1);

    // Words are always forwarded; only SEARCH and CONFIRM look at their content.
    always_ff @(posedge C) begin
        if (R) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            locked_q    <= 1'b0;
            slip_q      <= '0;
            sweep_q     <= '0;
            match_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            q_valid_q   <= boundary;
            align_err_q <= 1'b0;
            if (boundary) begin
                q_q <= word;
            end
            if (!ALIGN_EN) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        match_q  <= '0;
                        sweep_q  <= '0;
                    end
                    ST_SEARCH: begin
                        if (boundary) begin
                            if (pattern_hit) begin
                                match_q <= MATCH_CNT_W'(1);
                                if (LOCK_COUNT == 1) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end else begin
                                    state_q <= ST_CONFIRM;
                                end
                            end else begin
                                slip_q <= slip_inc;
                                // A full sweep of offsets without a hit is flagged, then retried.
                                if (sweep_q == SLIP_LAST) begin
                                    sweep_q     <= '0;
                                    align_err_q <= 1'b1;
                                end else begin
                                    sweep_q <= sweep_q + SW'(1);
                                end
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (boundary) begin
                            if (pattern_hit) begin
                                match_q <= match_inc;
                                if (match_inc == MATCH_CNT_W'(LOCK_COUNT)) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                state_q <= ST_SEARCH;
                                slip_q  <= slip_inc;
                                match_q <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        state_q <= ST_LOCKED;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Q         = q_q;
    assign Q_VALID   = q_valid_q;
    assign LOCKED    = locked_q;
    assign SLIP_CNT  = slip_q;
    assign ALIGN_ERR = align_err_q;

endmodule
